// File: rtl/alu_control.sv
// ALU control decode plus single-cycle ALU with registered outputs (1-cycle latency).
// Optional signed-overflow output is enabled by defining ALU_OVERFLOW_EN.
module alu_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        branch,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        pc_src
`ifdef ALU_OVERFLOW_EN
  ,
  output logic        overflow
`endif
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;
  localparam logic [3:0] CTRL_NOR = 4'b1100;
  localparam logic [3:0] CTRL_INV = 4'b1111;

  logic [3:0]  ctrl_next;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] res_next;
  logic        zero_next;

  always_comb begin
    ctrl_next = CTRL_INV;
    case (alu_op)
      2'b00: ctrl_next = CTRL_ADD;
      2'b01: ctrl_next = CTRL_SUB;
      2'b11: ctrl_next = CTRL_OR;
      default: begin
        case (funct)
          6'b100000: ctrl_next = CTRL_ADD;
          6'b100010: ctrl_next = CTRL_SUB;
          6'b100100: ctrl_next = CTRL_AND;
          6'b100101: ctrl_next = CTRL_OR;
          6'b100111: ctrl_next = CTRL_NOR;
          6'b101010: ctrl_next = CTRL_SLT;
          default:   ctrl_next = CTRL_INV;
        endcase
      end
    endcase
  end

  // Carry-out is intentionally dropped; ADD/SUB wrap modulo 2^32.
  always_comb begin
    sum      = a + b;
    diff     = a - b;
    res_next = 32'd0;
    case (ctrl_next)
      CTRL_AND: res_next = a & b;
      CTRL_OR:  res_next = a | b;
      CTRL_ADD: res_next = sum;
      CTRL_SUB: res_next = diff;
      CTRL_NOR: res_next = ~(a | b);
      CTRL_SLT: res_next = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:  res_next = 32'd0;
    endcase
    zero_next = (res_next == 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_ctrl <= CTRL_ADD;
      result   <= 32'd0;
      zero     <= 1'b1;
      pc_src   <= 1'b0;
    end else begin
      alu_ctrl <= ctrl_next;
      result   <= res_next;
      zero     <= zero_next;
      pc_src   <= branch & zero_next;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic ov_next;

  always_comb begin
    ov_next = 1'b0;
    case (ctrl_next)
      CTRL_ADD: ov_next = (a[31] == b[31]) && (sum[31] != a[31]);
      CTRL_SUB: ov_next = (a[31] != b[31]) && (diff[31] != a[31]);
      default:  ov_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) overflow <= 1'b0;
    else     overflow <= ov_next;
  end
`endif

endmodule

// File: tb/tb_alu_control.sv
// Scoreboard bench for alu_control: driver queues hand-computed expectations,
// a negedge monitor pops and compares one entry per issued cycle.
module tb_alu_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  alu_op = 2'b00;
  logic [5:0]  funct = 6'b000000;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        branch = 1'b0;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        pc_src;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  logic issue = 1'b0;
  logic out_valid = 1'b0;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] res;
    logic        z;
    logic        pc;
    logic        ov;
  } exp_t;

  exp_t sb_q[$];
  int   total  = 0;
  int   passed = 0;

  alu_control dut (
    .clk      (clk),
    .rst      (rst),
    .alu_op   (alu_op),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .branch   (branch),
    .alu_ctrl (alu_ctrl),
    .result   (result),
    .zero     (zero),
    .pc_src   (pc_src)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

  always #5 clk = ~clk;

  // Every issued cycle produces exactly one output one edge later.
  always @(posedge clk) out_valid <= issue;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s.%s actual=0x%08h required=0x%08h", name, field, act, exp);
  endtask

  task automatic checkOutput(input exp_t e);
    cmp(e.name, "alu_ctrl", {28'd0, alu_ctrl}, {28'd0, e.ctrl});
    cmp(e.name, "result",   result,            e.res);
    cmp(e.name, "zero",     {31'd0, zero},     {31'd0, e.z});
    cmp(e.name, "pc_src",   {31'd0, pc_src},   {31'd0, e.pc});
`ifdef ALU_OVERFLOW_EN
    cmp(e.name, "overflow", {31'd0, overflow}, {31'd0, e.ov});
`endif
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("[TB] FAIL scoreboard_underflow actual=empty required=entry");
      end else begin
        checkOutput(sb_q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input string name, input logic r, input logic [1:0] op,
                               input logic [5:0] f, input logic [31:0] va, input logic [31:0] vb,
                               input logic br, input logic [3:0] e_ctrl, input logic [31:0] e_res,
                               input logic e_z, input logic e_pc, input logic e_ov);
    exp_t e;
    @(negedge clk);
    rst    = r;
    alu_op = op;
    funct  = f;
    a      = va;
    b      = vb;
    branch = br;
    issue  = 1'b1;
    e.name = name;
    e.ctrl = e_ctrl;
    e.res  = e_res;
    e.z    = e_z;
    e.pc   = e_pc;
    e.ov   = e_ov;
    sb_q.push_back(e);
  endtask

  initial begin
    //            name          rst op     funct      a             b             br    ctrl     result        z     pc    ov
    applyStimulus("reset",      1, 2'b10, 6'b100000, 32'd5,        32'd7,        1'b1, 4'b0010, 32'd0,        1'b1, 1'b0, 1'b0);
    applyStimulus("add_5_7",    0, 2'b10, 6'b100000, 32'd5,        32'd7,        1'b0, 4'b0010, 32'd12,       1'b0, 1'b0, 1'b0);
    applyStimulus("sub_9_9",    0, 2'b10, 6'b100010, 32'd9,        32'd9,        1'b0, 4'b0110, 32'd0,        1'b1, 1'b0, 1'b0);
    applyStimulus("beq_taken",  0, 2'b01, 6'b000000, 32'h1234,     32'h1234,     1'b1, 4'b0110, 32'd0,        1'b1, 1'b1, 1'b0);
    applyStimulus("beq_not",    0, 2'b01, 6'b000000, 32'h1234,     32'h1235,     1'b1, 4'b0110, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("slt_m1_1",   0, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1,        1'b0, 4'b0111, 32'd1,        1'b0, 1'b0, 1'b0);
    applyStimulus("slt_1_m1",   0, 2'b10, 6'b101010, 32'd1,        32'hFFFFFFFF, 1'b0, 4'b0111, 32'd0,        1'b1, 1'b0, 1'b0);
    applyStimulus("nor_0_0",    0, 2'b10, 6'b100111, 32'd0,        32'd0,        1'b0, 4'b1100, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    applyStimulus("invalid",    0, 2'b10, 6'b000000, 32'd5,        32'd3,        1'b1, 4'b1111, 32'd0,        1'b1, 1'b1, 1'b0);
    applyStimulus("ori",        0, 2'b11, 6'b100010, 32'hF0,       32'h0F,       1'b0, 4'b0001, 32'hFF,       1'b0, 1'b0, 1'b0);
    applyStimulus("and",        0, 2'b10, 6'b100100, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 4'b0000, 32'h0F000F00, 1'b0, 1'b0, 1'b0);
    applyStimulus("or",         0, 2'b10, 6'b100101, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
    applyStimulus("sub_ignfn",  0, 2'b01, 6'b100000, 32'd10,       32'd3,        1'b0, 4'b0110, 32'd7,        1'b0, 1'b0, 1'b0);
    applyStimulus("add_ovf",    0, 2'b00, 6'b000000, 32'h7FFFFFFF, 32'd1,        1'b0, 4'b0010, 32'h80000000, 1'b0, 1'b0, 1'b1);
    applyStimulus("sub_ovf",    0, 2'b01, 6'b000000, 32'h80000000, 32'd1,        1'b0, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    applyStimulus("slt_minmax", 0, 2'b10, 6'b101010, 32'h80000000, 32'h7FFFFFFF, 1'b0, 4'b0111, 32'd1,        1'b0, 1'b0, 1'b0);
    applyStimulus("add_wrap",   0, 2'b00, 6'b101010, 32'hFFFFFFFF, 32'd1,        1'b1, 4'b0010, 32'd0,        1'b1, 1'b1, 1'b0);
    applyStimulus("add_noovf",  0, 2'b10, 6'b100000, 32'h40000000, 32'hC0000000, 1'b0, 4'b0010, 32'd0,        1'b1, 1'b0, 1'b0);
    applyStimulus("mid_reset",  1, 2'b10, 6'b100111, 32'd5,        32'd7,        1'b1, 4'b0010, 32'd0,        1'b1, 1'b0, 1'b0);
    applyStimulus("post_reset", 0, 2'b10, 6'b100010, 32'd3,        32'd5,        1'b0, 4'b0110, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    issue = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      total++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
